// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and the divider's control-state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

endpackage : alu_pkg

// File: rtl/subtractor.sv
// Combinational ripple borrow-chain subtractor: difference = operand_a - operand_b - borrow_in.
module subtractor
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] operand_a,
  input  logic [ALU_WIDTH-1:0] operand_b,
  input  logic                 borrow_in,
  output logic [ALU_WIDTH-1:0] difference,
  output logic                 borrow
);

  logic [ALU_WIDTH:0] borrow_chain;

  assign borrow_chain[0] = borrow_in;

  for (genvar i = 0; i < ALU_WIDTH; i++) begin : g_bit
    assign difference[i]     = operand_a[i] ^ operand_b[i] ^ borrow_chain[i];
    assign borrow_chain[i+1] = (~operand_a[i] & operand_b[i]) |
                               (~(operand_a[i] ^ operand_b[i]) & borrow_chain[i]);
  end

  assign borrow = borrow_chain[ALU_WIDTH];

endmodule : subtractor

// File: rtl/seq_divider4.sv
// Multi-cycle 4-bit unsigned restoring divider; one quotient bit per clock using the
// shared borrow-chain subtractor, with a start/done handshake toward the execute stage.
module seq_divider4
  import alu_pkg::*;
#(
  parameter logic [ALU_WIDTH-1:0] DIV0_QUOTIENT = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ALU_WIDTH-1:0] dividend,
  input  logic [ALU_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [ALU_WIDTH-1:0] quotient,
  output logic [ALU_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  div_state_t           state_q, state_d;
  logic [ALU_WIDTH-1:0] shift_q, shift_d;
  logic [ALU_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [ALU_WIDTH-1:0] rem_q, rem_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ALU_WIDTH-1:0] quotient_q, quotient_d;
  logic [ALU_WIDTH-1:0] remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;

  logic [ALU_WIDTH-1:0] sub_a;
  logic [ALU_WIDTH-1:0] sub_diff;
  logic                 sub_borrow;
  logic                 rem_msb;
  logic                 take;
  logic [ALU_WIDTH-1:0] rem_next;
  logic [ALU_WIDTH-1:0] shift_next;

  // Shift the next dividend bit into the partial remainder; the bit shifted out
  // of R extends it to 5 bits, in which case the subtraction always succeeds.
  assign rem_msb    = rem_q[ALU_WIDTH-1];
  assign sub_a      = {rem_q[ALU_WIDTH-2:0], shift_q[ALU_WIDTH-1]};
  assign take       = rem_msb | ~sub_borrow;
  assign rem_next   = take ? sub_diff : sub_a;
  assign shift_next = {shift_q[ALU_WIDTH-2:0], take};

  subtractor u_subtractor (
    .operand_a (sub_a),
    .operand_b (dvsr_q),
    .borrow_in (1'b0),
    .difference(sub_diff),
    .borrow    (sub_borrow)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      RUN: begin
        rem_d   = rem_next;
        shift_d = shift_next;
        if (cnt_q == 2'd0) begin
          quotient_d  = shift_next;
          remainder_d = rem_next;
          dbz_d       = 1'b0;
          state_d     = FIN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        // Results stay visible until the cycle done rises for the next operation.
        if (start) begin
          shift_d = dividend;
          dvsr_d  = divisor;
          rem_d   = '0;
          cnt_d   = 2'd3;
          if (divisor == '0) begin
            quotient_d  = DIV0_QUOTIENT;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = FIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      dvsr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= 2'd0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == FIN);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider4

// File: tb/tb_seq_divider4.sv
// Self-checking bench for seq_divider4: directed handshake/reset steps plus an
// exhaustive sweep, with expected results queued at start and popped at done.
module tb_seq_divider4;

  typedef struct {
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    int         busy_cycles;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  seq_divider4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive start at a negedge, queue the reference result, release start after the accept edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit hold);
    exp_t e;
    e.dvd         = a;
    e.dvs         = b;
    e.q           = (b == 4'd0) ? 4'hF : 4'(a / b);
    e.r           = (b == 4'd0) ? a : 4'(a % b);
    e.dbz         = (b == 4'd0);
    e.lat         = (b == 4'd0) ? 1 : 5;
    e.busy_cycles = (b == 4'd0) ? 0 : 4;
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done, then compare latency, busy duration and results.
  task automatic checkOutput();
    exp_t       e;
    int         n = 0;
    int         busy_seen = 0;
    logic [7:0] recon;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_seen++;
    end while (!done && n < 20);
    check("done_seen", {7'd0, done}, 8'd1);
    check("latency", 8'(n), 8'(e.lat));
    check("busy_cycles", 8'(busy_seen), 8'(e.busy_cycles));
    check("quotient", {4'd0, quotient}, {4'd0, e.q});
    check("remainder", {4'd0, remainder}, {4'd0, e.r});
    check("div_by_zero", {7'd0, div_by_zero}, {7'd0, e.dbz});
    if (e.dvs != 4'd0) begin
      recon = 8'({4'd0, quotient} * {4'd0, e.dvs} + {4'd0, remainder});
      check("invariant", recon, {4'd0, e.dvd});
    end
  endtask

  initial begin
    exp_t dropped;
    int   done_during_reset;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    #12;
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_done", {7'd0, done}, 8'd0);
    check("reset_quotient", {4'd0, quotient}, 8'd0);
    check("reset_remainder", {4'd0, remainder}, 8'd0);
    check("reset_dbz", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic and msb-path cases");
    applyStimulus(4'd13, 4'd3, 1'b0); checkOutput();
    @(negedge clk);
    check("done_single_pulse", {7'd0, done}, 8'd0);
    applyStimulus(4'd15, 4'd2, 1'b0); checkOutput();
    applyStimulus(4'd15, 4'd1, 1'b0); checkOutput();
    applyStimulus(4'd14, 4'd15, 1'b0); checkOutput();
    applyStimulus(4'd9, 4'd9, 1'b0); checkOutput();
    @(negedge clk);

    $display("[TB] divide by zero");
    applyStimulus(4'd7, 4'd0, 1'b0); checkOutput();
    @(negedge clk);
    applyStimulus(4'd8, 4'd4, 1'b0); checkOutput();
    @(negedge clk);

    $display("[TB] start held, inputs changed mid-run");
    applyStimulus(4'd13, 4'd3, 1'b1);
    dividend = 4'd2;
    divisor  = 4'd1;
    @(negedge clk);
    dividend = 4'd5;
    divisor  = 4'd0;
    check("busy_ignores_start", {7'd0, busy}, 8'd1);
    sb[0].lat = 4;
    sb[0].busy_cycles = 3;
    checkOutput();
    start = 1'b0;
    @(negedge clk);

    $display("[TB] back-to-back via start in FIN");
    applyStimulus(4'd12, 4'd5, 1'b0); checkOutput();
    applyStimulus(4'd11, 4'd4, 1'b0); checkOutput();
    @(negedge clk);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(4'd11, 4'd2, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {7'd0, busy}, 8'd0);
    check("midreset_done", {7'd0, done}, 8'd0);
    check("midreset_quotient", {4'd0, quotient}, 8'd0);
    check("midreset_remainder", {4'd0, remainder}, 8'd0);
    check("midreset_dbz", {7'd0, div_by_zero}, 8'd0);
    dropped = sb.pop_back();
    done_during_reset = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_during_reset++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_during_reset++;
    end
    check("no_done_after_abort", 8'(done_during_reset), 8'd0);
    applyStimulus(4'd6, 4'd4, 1'b0); checkOutput();
    @(negedge clk);

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), 1'b0);
        checkOutput();
        if (((a + b) % 3) == 0) @(negedge clk);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_seq_divider4
